control_unit: RTL and testbench

- Multi-cycle FSM sequencer that sits directly upstream of Processing_Unit. It drives every register-load, PC and bus-mux control input of that unit.
- Consumes the fetched instruction, Zflag and the current memory word.
- Produces a fetch/decode/execute schedule per instruction, plus the registered address/constant operands for two-word instructions and the memory write strobe.

---
 rtl/control_unit_if.sv | 42 ++++
 rtl/control_unit.sv | 203 ++++++++++++++++++++
 tb/tb_control_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// control_unit_if: bundles the instruction/flag/memory inputs and every
// control output that the sequencer drives into Processing_Unit.
//   master : seen by control_unit (consumes instruction/Zflag/mem_word,
//            drives loads, muxes, write strobe, decoded operands, status)
//   slave  : seen by Processing_Unit / testbench (the mirror image)
interface control_unit_if #(
    parameter int word_size = 10,
    parameter int Sel1_size = 3,
    parameter int Sel2_size = 3
);
    logic [word_size-1:0] instruction;
    logic                 Zflag;
    logic [word_size-1:0] mem_word;

    logic                 Load_R0, Load_R1, Load_R2, Load_R3;
    logic                 Load_PC, Inc_PC;
    logic [Sel1_size-1:0] Sel_Bus_1a_Mux;
    logic [Sel1_size-1:0] Sel_Bus_1b_Mux;
    logic [Sel2_size-1:0] Sel_Bus_2_Mux;
    logic                 Load_IR, Load_Add_R, Load_Reg_Z;
    logic                 write;
    logic [6:0]           address_decoded;
    logic [7:0]           constant_decoded;
    logic                 halted;
    logic                 illegal;

    modport master (
        input  instruction, Zflag, mem_word,
        output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
               Sel_Bus_1a_Mux, Sel_Bus_1b_Mux, Sel_Bus_2_Mux,
               Load_IR, Load_Add_R, Load_Reg_Z, write,
               address_decoded, constant_decoded, halted, illegal
    );

    modport slave (
        output instruction, Zflag, mem_word,
        input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
               Sel_Bus_1a_Mux, Sel_Bus_1b_Mux, Sel_Bus_2_Mux,
               Load_IR, Load_Add_R, Load_Reg_Z, write,
               address_decoded, constant_decoded, halted, illegal
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for Processing_Unit.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : control_unit_if.master -- instruction, Zflag, mem_word in;
//          register/PC/IR/Add_R/Z loads, bus mux selects, write strobe,
//          registered operand address/constant, halted and illegal out.
// Controls are a combinational decode of the state register (and the
// instruction / Zflag where needed); the only flops are the state and the
// two operand registers captured while the operand word is on mem_word.
module control_unit #(
    parameter int word_size = 10,
    parameter int op_size   = 4,
    parameter int Sel1_size = 3,
    parameter int Sel2_size = 3
) (
    input logic          clk,
    input logic          rst,
    control_unit_if.master bus
);
    localparam logic [3:0] S_idle = 4'd0;
    localparam logic [3:0] S_fet1 = 4'd1;
    localparam logic [3:0] S_fet2 = 4'd2;
    localparam logic [3:0] S_dec  = 4'd3;
    localparam logic [3:0] S_ex1  = 4'd4;
    localparam logic [3:0] S_op   = 4'd5;
    localparam logic [3:0] S_adr  = 4'd6;
    localparam logic [3:0] S_rd   = 4'd7;
    localparam logic [3:0] S_wr   = 4'd8;
    localparam logic [3:0] S_br   = 4'd9;
    localparam logic [3:0] S_ldi  = 4'd10;
    localparam logic [3:0] S_halt = 4'd11;

    localparam logic [op_size-1:0] OP_NOP  = 4'd0;
    localparam logic [op_size-1:0] OP_NOT  = 4'd4;
    localparam logic [op_size-1:0] OP_RD   = 4'd5;
    localparam logic [op_size-1:0] OP_WR   = 4'd6;
    localparam logic [op_size-1:0] OP_BR   = 4'd7;
    localparam logic [op_size-1:0] OP_BRZ  = 4'd8;
    localparam logic [op_size-1:0] OP_LDI  = 4'd9;
    localparam logic [op_size-1:0] OP_HALT = 4'd15;

    localparam logic [Sel1_size-1:0] SEL1_PC    = Sel1_size'(4);
    localparam logic [Sel2_size-1:0] SEL2_ALU   = Sel2_size'(0);
    localparam logic [Sel2_size-1:0] SEL2_BUS1A = Sel2_size'(1);
    localparam logic [Sel2_size-1:0] SEL2_MEM   = Sel2_size'(2);
    localparam logic [Sel2_size-1:0] SEL2_CONST = Sel2_size'(3);
    localparam logic [Sel2_size-1:0] SEL2_ADDR  = Sel2_size'(4);

    logic [3:0] state, nxt;
    logic [6:0] addr_q;
    logic [7:0] const_q;

    logic [op_size-1:0] op;
    logic [1:0]         dest, src1, src2;
    logic               is_alu, is_two_word;

    assign op   = bus.instruction[word_size-1 -: op_size];
    assign dest = bus.instruction[5:4];
    assign src1 = bus.instruction[3:2];
    assign src2 = bus.instruction[1:0];

    assign is_alu      = (op != OP_NOP) && (op <= OP_NOT);
    assign is_two_word = (op >= OP_RD) && (op <= OP_LDI);

    // operand word upper bits carry nothing for this machine
    logic unused_mem_bits;
    assign unused_mem_bits = ^bus.mem_word[word_size-1:8];

    logic                 ld_reg;
    logic                 load_pc, inc_pc, load_ir, load_add_r, load_reg_z;
    logic                 wr, halt_o, illegal_o;
    logic [Sel1_size-1:0] sel1a, sel1b;
    logic [Sel2_size-1:0] sel2;

    always_comb begin
        nxt        = state;
        ld_reg     = 1'b0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_z = 1'b0;
        wr         = 1'b0;
        halt_o     = 1'b0;
        illegal_o  = 1'b0;
        sel1a      = '0;
        sel1b      = '0;
        sel2       = '0;
        case (state)
            S_idle: nxt = S_fet1;
            S_fet1: begin
                sel1a      = SEL1_PC;
                sel2       = SEL2_BUS1A;
                load_add_r = 1'b1;
                nxt        = S_fet2;
            end
            S_fet2: begin
                sel2    = SEL2_MEM;
                load_ir = 1'b1;
                inc_pc  = 1'b1;
                nxt     = S_dec;
            end
            S_dec: begin
                if (is_alu) begin
                    sel1a = Sel1_size'(src1);
                    sel1b = Sel1_size'(src2);
                    nxt   = S_ex1;
                end else if (op == OP_NOP) begin
                    nxt = S_fet1;
                end else if (is_two_word) begin
                    // point Add_R at the operand word (PC already advanced)
                    sel1a      = SEL1_PC;
                    sel2       = SEL2_BUS1A;
                    load_add_r = 1'b1;
                    nxt        = S_op;
                end else if (op == OP_HALT) begin
                    nxt = S_halt;
                end else begin
                    illegal_o = 1'b1;
                    nxt       = S_fet1;
                end
            end
            S_ex1: begin
                sel1a      = Sel1_size'(src1);
                sel1b      = Sel1_size'(src2);
                sel2       = SEL2_ALU;
                load_reg_z = 1'b1;
                ld_reg     = 1'b1;
                nxt        = S_fet1;
            end
            S_op: begin
                inc_pc = 1'b1;
                if (op == OP_RD || op == OP_WR)       nxt = S_adr;
                else if (op == OP_BR || op == OP_BRZ) nxt = S_br;
                else                                  nxt = S_ldi;
            end
            S_adr: begin
                sel2       = SEL2_ADDR;
                load_add_r = 1'b1;
                nxt        = (op == OP_WR) ? S_wr : S_rd;
            end
            S_rd: begin
                sel2   = SEL2_MEM;
                ld_reg = 1'b1;
                nxt    = S_fet1;
            end
            S_wr: begin
                sel1a = Sel1_size'(src1);
                wr    = 1'b1;
                nxt   = S_fet1;
            end
            S_br: begin
                sel2    = SEL2_ADDR;
                load_pc = (op == OP_BR) || bus.Zflag;
                nxt     = S_fet1;
            end
            S_ldi: begin
                sel2   = SEL2_CONST;
                ld_reg = 1'b1;
                nxt    = S_fet1;
            end
            S_halt: begin
                halt_o = 1'b1;
                nxt    = S_halt;
            end
            default: nxt = S_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_idle;
            addr_q  <= '0;
            const_q <= '0;
        end else begin
            state <= nxt;
            // mem_word holds the operand word while in S_op
            if (state == S_op) begin
                addr_q  <= bus.mem_word[6:0];
                const_q <= bus.mem_word[7:0];
            end
        end
    end

    assign bus.Load_R0          = ld_reg && (dest == 2'd0);
    assign bus.Load_R1          = ld_reg && (dest == 2'd1);
    assign bus.Load_R2          = ld_reg && (dest == 2'd2);
    assign bus.Load_R3          = ld_reg && (dest == 2'd3);
    assign bus.Load_PC          = load_pc;
    assign bus.Inc_PC           = inc_pc;
    assign bus.Sel_Bus_1a_Mux   = sel1a;
    assign bus.Sel_Bus_1b_Mux   = sel1b;
    assign bus.Sel_Bus_2_Mux    = sel2;
    assign bus.Load_IR          = load_ir;
    assign bus.Load_Add_R       = load_add_r;
    assign bus.Load_Reg_Z       = load_reg_z;
    assign bus.write            = wr;
    assign bus.address_decoded  = addr_q;
    assign bus.constant_decoded = const_q;
    assign bus.halted           = halt_o;
    assign bus.illegal          = illegal_o;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed + random instruction stream against a schedule
// model that lists, per instruction class, the control word of every cycle.
module tb_control_unit;
    logic clk = 1'b0;
    logic rst;

    control_unit_if #(.word_size(10), .Sel1_size(3), .Sel2_size(3)) bus ();

    control_unit #(.word_size(10), .op_size(4), .Sel1_size(3), .Sel2_size(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ld_r;   // {R3,R2,R1,R0}
        logic       ld_pc;
        logic       inc_pc;
        logic [2:0] s1a;
        logic [2:0] s1b;
        logic [2:0] s2;
        logic       ld_ir;
        logic       ld_add;
        logic       ld_z;
        logic       wr;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    ctrl_t obs;
    always_comb begin
        obs        = '0;
        obs.ld_r   = {bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0};
        obs.ld_pc  = bus.Load_PC;
        obs.inc_pc = bus.Inc_PC;
        obs.s1a    = bus.Sel_Bus_1a_Mux;
        obs.s1b    = bus.Sel_Bus_1b_Mux;
        obs.s2     = bus.Sel_Bus_2_Mux;
        obs.ld_ir  = bus.Load_IR;
        obs.ld_add = bus.Load_Add_R;
        obs.ld_z   = bus.Load_Reg_Z;
        obs.wr     = bus.write;
        obs.halted = bus.halted;
        obs.illegal = bus.illegal;
    end

    int n_chk = 0;
    int n_err = 0;
    logic [6:0] exp_addr;
    logic [7:0] exp_const;

    task automatic chk_ctrl(input ctrl_t exp, input string tag);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_operands(input string tag);
        n_chk++;
        assert ({bus.address_decoded, bus.constant_decoded} === {exp_addr, exp_const}) else begin
            n_err++;
            $error("FAIL %s observed=%h/%h expected=%h/%h", tag,
                   bus.address_decoded, bus.constant_decoded, exp_addr, exp_const);
        end
    endtask

    // one cycle with no controls expected (S_idle), also checks operand regs
    task automatic idle_cycle(input string tag);
        @(negedge clk);
        chk_ctrl('0, tag);
        chk_operands(tag);
        @(posedge clk); #1;
    endtask

    function automatic ctrl_t addr_from_pc();
        ctrl_t c = '0;
        c.s1a = 3'd4; c.s2 = 3'd1; c.ld_add = 1'b1;
        return c;
    endfunction

    // Called #1 after the edge that enters S_fet1. abort_idx >= 0 asserts
    // rst during that cycle of the schedule and stops there.
    task automatic run_instr(input logic [9:0] ins, input logic [9:0] opw,
                             input logic z, input int abort_idx, input string tag);
        ctrl_t q[$];
        ctrl_t c;
        int op_idx = -1;
        int br_idx = -1;
        logic [3:0] op   = ins[9:6];
        logic [1:0] dest = ins[5:4];
        logic [1:0] s1   = ins[3:2];
        logic [1:0] s2   = ins[1:0];
        logic [3:0] onehot = 4'b0001 << dest;

        q.push_back(addr_from_pc());
        c = '0; c.s2 = 3'd2; c.ld_ir = 1'b1; c.inc_pc = 1'b1; q.push_back(c);
        case (op)
            4'd0, 4'd15: q.push_back('0);
            4'd1, 4'd2, 4'd3, 4'd4: begin
                c = '0; c.s1a = {1'b0, s1}; c.s1b = {1'b0, s2}; q.push_back(c);
                c.s2 = 3'd0; c.ld_z = 1'b1; c.ld_r = onehot; q.push_back(c);
            end
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                q.push_back(addr_from_pc());
                op_idx = q.size();
                c = '0; c.inc_pc = 1'b1; q.push_back(c);
                if (op == 4'd5 || op == 4'd6) begin
                    c = '0; c.s2 = 3'd4; c.ld_add = 1'b1; q.push_back(c);
                    c = '0;
                    if (op == 4'd5) begin c.s2 = 3'd2; c.ld_r = onehot; end
                    else begin c.s1a = {1'b0, s1}; c.wr = 1'b1; end
                    q.push_back(c);
                end else if (op == 4'd9) begin
                    c = '0; c.s2 = 3'd3; c.ld_r = onehot; q.push_back(c);
                end else begin
                    br_idx = q.size();
                    c = '0; c.s2 = 3'd4; c.ld_pc = (op == 4'd7) || z; q.push_back(c);
                end
            end
            default: begin c = '0; c.illegal = 1'b1; q.push_back(c); end
        endcase

        bus.instruction = ins;
        foreach (q[i]) begin
            bus.mem_word = (i == op_idx) ? opw : 10'($urandom);
            bus.Zflag    = (i == br_idx) ? z : 1'($urandom);
            if (i == abort_idx) rst = 1'b1;
            @(negedge clk);
            chk_ctrl(q[i], $sformatf("%s[%0d]", tag, i));
            @(posedge clk); #1;
            if (i == abort_idx) begin
                rst = 1'b0;
                exp_addr = '0; exp_const = '0;
                return;
            end
            if (i == op_idx) begin
                exp_addr = opw[6:0]; exp_const = opw[7:0];
                chk_operands({tag, "_operand"});
            end
        end
    endtask

    initial begin
        ctrl_t hc;
        rst = 1'b1;
        bus.instruction = '0;
        bus.Zflag = 1'b0;
        bus.mem_word = '0;
        exp_addr = '0; exp_const = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_ctrl('0, "reset_ctrl");
        chk_operands("reset_operands");
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycle("idle_after_reset");

        run_instr(10'b0001_00_01_10, 10'h000, 1'b0, -1, "add");
        run_instr(10'b1001_11_00_00, 10'h0A5, 1'b0, -1, "ldi_r3");
        run_instr(10'b1000_00_00_00, 10'h02C, 1'b1, -1, "brz_taken");
        run_instr(10'b1000_00_00_00, 10'h02C, 1'b0, -1, "brz_not_taken");
        run_instr(10'b0111_00_00_00, 10'h155, 1'b0, -1, "br");
        run_instr(10'b0110_00_10_00, 10'h010, 1'b0, -1, "wr_r2");
        run_instr(10'b0101_01_00_00, 10'h37F, 1'b0, -1, "rd_r1");
        run_instr(10'b1011_00_00_00, 10'h000, 1'b0, -1, "illegal_b");
        run_instr(10'b0000_00_00_00, 10'h000, 1'b0, -1, "nop");

        for (int k = 0; k < 60; k++) begin
            logic [9:0] ins;
            ins = 10'($urandom);
            ins[9:6] = 4'($urandom_range(0, 14));
            run_instr(ins, 10'($urandom), 1'($urandom), -1, $sformatf("rnd%0d", k));
        end

        // reset during S_ex1 of an ADD (schedule index 3)
        run_instr(10'b0001_00_01_10, 10'h000, 1'b0, 3, "add_abort");
        idle_cycle("idle_after_abort");
        run_instr(10'b1001_10_00_00, 10'h0C3, 1'b0, -1, "ldi_after_abort");

        // HALT then 20 held cycles, then reset out of it
        run_instr(10'b1111_00_00_00, 10'h000, 1'b0, -1, "halt");
        hc = '0; hc.halted = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.Zflag = 1'($urandom);
            bus.mem_word = 10'($urandom);
            bus.instruction = 10'($urandom);
            @(negedge clk);
            chk_ctrl(hc, $sformatf("halt_hold%0d", k));
            @(posedge clk); #1;
        end
        bus.instruction = 10'b1111_00_00_00;
        rst = 1'b1;
        @(negedge clk);
        chk_ctrl(hc, "halt_rst_cycle");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_addr = '0; exp_const = '0;
        idle_cycle("idle_after_halt");
        run_instr(10'b0011_01_11_00, 10'h000, 1'b0, -1, "and_after_halt");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
